// File: rtl/fan_speed_timer_fsm_if.sv
// Button-pulse and fan-status bundle between the button front end and the
// fan control FSM. The slave side is the FSM itself.
interface fan_speed_timer_fsm_if;
  logic       i_btn_onoff;
  logic       i_btn_speed;
  logic       i_btn_timer;
  logic       o_FANOnOff;
  logic [3:0] o_1000_value;
  logic [7:0] o_timer_sec;
  logic       o_timer_active;

  modport master (
    output i_btn_onoff, i_btn_speed, i_btn_timer,
    input  o_FANOnOff, o_1000_value, o_timer_sec, o_timer_active
  );

  modport slave (
    input  i_btn_onoff, i_btn_speed, i_btn_timer,
    output o_FANOnOff, o_1000_value, o_timer_sec, o_timer_active
  );
endinterface

// File: rtl/fan_speed_timer_fsm.sv
// Fan on/off and speed-level controller with an optional auto-off countdown
// timer; drives the select inputs of the downstream fan output multiplexer.
module fan_speed_timer_fsm #(
  parameter int SEC_DIV    = 100_000_000,
  parameter int TIMER_STEP = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  fan_speed_timer_fsm_if.slave  fan
);

  localparam int         PW       = $clog2(SEC_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SEC_DIV - 1);
  localparam logic [7:0] STEP8    = 8'(TIMER_STEP);

  typedef enum logic {
    S_OFF = 1'b0,
    S_ON  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    speed_q, speed_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    sec_q, sec_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          active_q;

  logic       running;
  logic       sec_tick;
  logic [1:0] idx_next;

  assign running  = (sec_q != 8'd0);
  assign sec_tick = running && (presc_q == PRESC_LAST);
  assign idx_next = idx_q + 2'd1;

  // NOTE: every next-state variable gets its hold value first, so no path
  // through the priority chain below can leave one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    idx_d   = idx_q;
    sec_d   = sec_q;
    presc_d = running ? (sec_tick ? '0 : presc_q + PW'(1)) : '0;

    unique case (state_q)
      S_OFF: begin
        if (fan.i_btn_onoff) begin
          state_d = S_ON;
          speed_d = 2'd1;
          idx_d   = 2'd0;
          sec_d   = 8'd0;
          presc_d = '0;
        end
      end

      S_ON: begin
        if (fan.i_btn_onoff) begin
          state_d = S_OFF;
          speed_d = 2'd0;
          idx_d   = 2'd0;
          sec_d   = 8'd0;
          presc_d = '0;
        end else if (fan.i_btn_timer) begin
          // Reload beats a same-cycle expiry; preset 0 cancels the timer.
          idx_d   = idx_next;
          sec_d   = {6'd0, idx_next} * STEP8;
          presc_d = '0;
        end else if (sec_tick && sec_q == 8'd1) begin
          state_d = S_OFF;
          speed_d = 2'd0;
          idx_d   = 2'd0;
          sec_d   = 8'd0;
        end else begin
          if (sec_tick) sec_d = sec_q - 8'd1;
          if (fan.i_btn_speed) speed_d = (speed_q == 2'd3) ? 2'd1 : speed_q + 2'd1;
        end
      end

      default: state_d = S_OFF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q  <= S_OFF;
      speed_q  <= 2'd0;
      idx_q    <= 2'd0;
      sec_q    <= 8'd0;
      presc_q  <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      speed_q  <= speed_d;
      idx_q    <= idx_d;
      sec_q    <= sec_d;
      presc_q  <= presc_d;
      active_q <= (sec_d != 8'd0);
    end
  end

  assign fan.o_FANOnOff     = (state_q == S_ON);
  assign fan.o_1000_value   = {2'b00, speed_q};
  assign fan.o_timer_sec    = sec_q;
  assign fan.o_timer_active = active_q;

endmodule

// File: tb/tb_fan_speed_timer_fsm.sv
// Directed bench for fan_speed_timer_fsm with SEC_DIV=10, TIMER_STEP=2;
// expected values are hand-derived from the cycle timing of each scenario.
module tb_fan_speed_timer_fsm;
  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  int   total  = 0;
  int   passed = 0;

  fan_speed_timer_fsm_if fan ();

  fan_speed_timer_fsm #(.SEC_DIV(10), .TIMER_STEP(2)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .fan       (fan)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    else passed++;
  endtask

  task automatic check_out(input string tag, input logic on, input logic [3:0] spd,
                           input logic [7:0] sec);
    check({tag, ".on"},     32'(fan.o_FANOnOff),     32'(on));
    check({tag, ".speed"},  32'(fan.o_1000_value),   32'(spd));
    check({tag, ".sec"},    32'(fan.o_timer_sec),    32'(sec));
    check({tag, ".active"}, 32'(fan.o_timer_active), 32'(sec != 8'd0));
  endtask

  // Advance n rising edges; returns 1 time unit after the last edge.
  task automatic edges(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Hold the given buttons for exactly one sampling edge.
  task automatic press(input logic onoff, input logic spd, input logic tmr);
    @(negedge i_clk);
    fan.i_btn_onoff = onoff;
    fan.i_btn_speed = spd;
    fan.i_btn_timer = tmr;
    @(posedge i_clk);
    #1;
    fan.i_btn_onoff = 1'b0;
    fan.i_btn_speed = 1'b0;
    fan.i_btn_timer = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge i_clk);
    i_reset_n = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
  endtask

  initial begin
    fan.i_btn_onoff = 1'b0;
    fan.i_btn_speed = 1'b0;
    fan.i_btn_timer = 1'b0;
    edges(2);
    check_out("reset", 1'b0, 4'd0, 8'd0);
    i_reset_n = 1'b1;
    edges(1);

    // 1: turn on, speed cycling
    press(1, 0, 0); check_out("on", 1'b1, 4'd1, 8'd0);
    press(0, 1, 0); check_out("spd2", 1'b1, 4'd2, 8'd0);
    press(0, 1, 0); check_out("spd3", 1'b1, 4'd3, 8'd0);
    press(0, 1, 0); check_out("spd1", 1'b1, 4'd1, 8'd0);
    press(0, 1, 0); check_out("spd2b", 1'b1, 4'd2, 8'd0);

    // 2: buttons ignored while off
    press(1, 0, 0); check_out("off", 1'b0, 4'd0, 8'd0);
    press(0, 1, 0); check_out("off_spd", 1'b0, 4'd0, 8'd0);
    press(0, 0, 1); check_out("off_tmr", 1'b0, 4'd0, 8'd0);
    press(1, 0, 0); check_out("on2", 1'b1, 4'd1, 8'd0);

    // 3: 2 s countdown to auto-off
    press(0, 0, 1); check_out("load2", 1'b1, 4'd1, 8'd2);
    edges(9);       check_out("pre_dec", 1'b1, 4'd1, 8'd2);
    edges(1);       check_out("dec1", 1'b1, 4'd1, 8'd1);
    edges(9);       check_out("pre_exp", 1'b1, 4'd1, 8'd1);
    edges(1);       check_out("expire", 1'b0, 4'd0, 8'd0);

    // 4: preset cycle back to cancelled, fan stays on
    press(1, 0, 0); check_out("on3", 1'b1, 4'd1, 8'd0);
    press(0, 0, 1); check_out("pre1", 1'b1, 4'd1, 8'd2);
    press(0, 0, 1); check_out("pre2", 1'b1, 4'd1, 8'd4);
    press(0, 0, 1); check_out("pre3", 1'b1, 4'd1, 8'd6);
    press(0, 0, 1); check_out("pre0", 1'b1, 4'd1, 8'd0);
    edges(100);     check_out("hold", 1'b1, 4'd1, 8'd0);

    // 5a: timer pulse on the expiry tick reloads
    press(0, 0, 1); check_out("c_load", 1'b1, 4'd1, 8'd2);
    edges(10);      check_out("c_at1", 1'b1, 4'd1, 8'd1);
    edges(9);
    press(0, 0, 1); check_out("c_reload", 1'b1, 4'd1, 8'd4);

    // 5b: speed pulse on the expiry tick is dropped, fan goes off
    press(0, 0, 1); check_out("c_pre3", 1'b1, 4'd1, 8'd6);
    press(0, 0, 1); check_out("c_pre0", 1'b1, 4'd1, 8'd0);
    press(0, 0, 1); check_out("c_pre1", 1'b1, 4'd1, 8'd2);
    edges(19);
    press(0, 1, 0); check_out("c_spd_exp", 1'b0, 4'd0, 8'd0);

    // 5c: multiple buttons, onoff dominates
    press(1, 0, 0); check_out("on4", 1'b1, 4'd1, 8'd0);
    press(1, 1, 0); check_out("onoff_spd", 1'b0, 4'd0, 8'd0);
    press(1, 0, 1); check_out("onoff_tmr", 1'b1, 4'd1, 8'd0);

    // 6: reset mid-countdown discards timer and preset index
    press(0, 0, 1); press(0, 0, 1); press(0, 0, 1);
    check_out("r_load6", 1'b1, 4'd1, 8'd6);
    edges(10);      check_out("r_at5", 1'b1, 4'd1, 8'd5);
    pulse_reset();  check_out("r_reset", 1'b0, 4'd0, 8'd0);
    edges(12);      check_out("r_idle", 1'b0, 4'd0, 8'd0);
    press(1, 0, 0); check_out("r_on", 1'b1, 4'd1, 8'd0);
    press(0, 0, 1); check_out("r_idx0", 1'b1, 4'd1, 8'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
